// File: rtl/flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// flash_read_arbiter
//
// Shares one SPI flash between two 32-bit word-read requesters. After reset it
// sends the 0xAB release-from-power-down command, waits WAKE_WAIT_CYCLES with
// CS high, then serves reads with 0x03 READ transactions in SPI mode 0 at
// clk/2. Requests are arbitrated round-robin; after reset port A has priority.
//
// Optional feature macro: FLASH_ARB_SEQ_EN
//   When defined, CS is held low after a read (HOLD). A sequential word
//   request from the same port then continues the burst with 32 more data
//   clocks instead of a new command/address header.
//
// Parameters
//   WAKE_WAIT_CYCLES  cycles with CS high after the wake command (>= 1)
//   CS_GAP_CYCLES     minimum CS-high cycles between transactions (>= 1)
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   a_valid/a_addr        port A request (held until a_ready)
//   a_ready/a_rdata       port A one-cycle completion pulse and read word
//   b_valid/b_addr        port B request (held until b_ready)
//   b_ready/b_rdata       port B one-cycle completion pulse and read word
//   flash_csn/sck/mosi    SPI outputs to the flash
//   flash_miso            SPI data from the flash
// -----------------------------------------------------------------------------
module flash_read_arbiter #(
    parameter int WAKE_WAIT_CYCLES = 48,
    parameter int CS_GAP_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [23:0] a_addr,
    output logic        a_ready,
    output logic [31:0] a_rdata,
    input  logic        b_valid,
    input  logic [23:0] b_addr,
    output logic        b_ready,
    output logic [31:0] b_rdata,
    output logic        flash_csn,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    // state      | meaning
    // -----------+-------------------------------------------------------
    // ST_WAKE    | first cycle drops CS, then shifts out 0xAB
    // ST_WAKE_WAIT| CS high, counting down the flash wake-up time
    // ST_IDLE    | round-robin arbitration between A and B
    // ST_SHIFT   | clocking command, address and data bits
    // ST_GAP     | CS high for the minimum deselect time
    // ST_HOLD    | (FLASH_ARB_SEQ_EN) CS low, waiting for a sequential word
    typedef enum logic [2:0] {
        ST_WAKE,
        ST_WAKE_WAIT,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
`ifdef FLASH_ARB_SEQ_EN
        , ST_HOLD
`endif
    } state_t;

    localparam logic [15:0] WAIT_LOAD = 16'(WAKE_WAIT_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(CS_GAP_CYCLES - 1);
    localparam logic [7:0]  CMD_WAKE  = 8'hAB;
    localparam logic [7:0]  CMD_READ  = 8'h03;

    state_t      state_q;
    logic        csn_q;
    logic        sck_q;
    logic        mosi_q;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic [5:0]  bits_q;      // bits remaining after the one on MOSI now
    logic [15:0] cnt_q;
    logic        last_b_q;    // last served port, also the current owner
    logic        a_ready_q;
    logic        b_ready_q;
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;

    logic        grant_a;
    logic        grant_b;
    logic [21:0] grant_word;
    logic [31:0] cmd_word;
    logic [31:0] rx_word;
    logic        unused_addr_lsbs;

    // Tie goes to the port that was not served last.
    assign grant_a    = a_valid && (!b_valid || last_b_q);
    assign grant_b    = b_valid && (!a_valid || !last_b_q);
    assign grant_word = grant_a ? a_addr[23:2] : b_addr[23:2];
    assign cmd_word   = {CMD_READ, grant_word, 2'b00};

    // rx_q holds the data stream MSB-first, first byte in [31:24]; the
    // returned word is little-endian, so the bytes are reversed.
    assign rx_word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

    assign unused_addr_lsbs = ^{a_addr[1:0], b_addr[1:0]};

`ifdef FLASH_ARB_SEQ_EN
    logic [21:0] word_q;
    logic        own_valid;
    logic        other_valid;
    logic        seq_hit;

    assign own_valid   = last_b_q ? b_valid : a_valid;
    assign other_valid = last_b_q ? a_valid : b_valid;
    assign seq_hit     = (last_b_q ? b_addr[23:2] : a_addr[23:2]) == (word_q + 22'd1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_WAKE;
            csn_q     <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            bits_q    <= '0;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef FLASH_ARB_SEQ_EN
            word_q    <= '0;
`endif
        end else begin
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            case (state_q)
                ST_WAKE: begin
                    if (csn_q) begin
                        csn_q  <= 1'b0;
                        mosi_q <= CMD_WAKE[7];
                        tx_q   <= {CMD_WAKE[6:0], 25'd0};
                        bits_q <= 6'd7;
                    end else if (!sck_q) begin
                        sck_q <= 1'b1;
                    end else begin
                        sck_q <= 1'b0;
                        if (bits_q == 6'd0) begin
                            csn_q   <= 1'b1;
                            mosi_q  <= 1'b0;
                            cnt_q   <= WAIT_LOAD;
                            state_q <= ST_WAKE_WAIT;
                        end else begin
                            bits_q <= bits_q - 6'd1;
                            mosi_q <= tx_q[31];
                            tx_q   <= {tx_q[30:0], 1'b0};
                        end
                    end
                end

                ST_WAKE_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                ST_IDLE: begin
                    if (grant_a || grant_b) begin
                        csn_q    <= 1'b0;
                        sck_q    <= 1'b0;
                        mosi_q   <= cmd_word[31];
                        tx_q     <= {cmd_word[30:0], 1'b0};
                        bits_q   <= 6'd63;
                        last_b_q <= grant_b;
`ifdef FLASH_ARB_SEQ_EN
                        word_q   <= grant_word;
`endif
                        state_q  <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (!sck_q) begin
                        // Sample on the edge that raises SCK.
                        sck_q <= 1'b1;
                        rx_q  <= {rx_q[30:0], flash_miso};
                    end else begin
                        sck_q <= 1'b0;
                        if (bits_q == 6'd0) begin
                            if (last_b_q) begin
                                b_ready_q <= 1'b1;
                                b_rdata_q <= rx_word;
                            end else begin
                                a_ready_q <= 1'b1;
                                a_rdata_q <= rx_word;
                            end
`ifdef FLASH_ARB_SEQ_EN
                            state_q <= ST_HOLD;
`else
                            csn_q   <= 1'b1;
                            cnt_q   <= GAP_LOAD;
                            state_q <= ST_GAP;
`endif
                        end else begin
                            // tx_q is all zero once the header is out, so
                            // the data phase drives MOSI low.
                            bits_q <= bits_q - 6'd1;
                            mosi_q <= tx_q[31];
                            tx_q   <= {tx_q[30:0], 1'b0};
                        end
                    end
                end

                ST_GAP: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

`ifdef FLASH_ARB_SEQ_EN
                ST_HOLD: begin
                    // The first HOLD cycle is the ready cycle, where the
                    // requester still shows the request just completed.
                    if (!(a_ready_q || b_ready_q)) begin
                        if (other_valid || (own_valid && !seq_hit)) begin
                            csn_q   <= 1'b1;
                            cnt_q   <= GAP_LOAD;
                            state_q <= ST_GAP;
                        end else if (own_valid) begin
                            word_q  <= word_q + 22'd1;
                            mosi_q  <= 1'b0;
                            tx_q    <= '0;
                            bits_q  <= 6'd31;
                            state_q <= ST_SHIFT;
                        end
                    end
                end
`endif

                default: state_q <= ST_WAKE;
            endcase
        end
    end

    assign flash_csn  = csn_q;
    assign flash_sck  = sck_q;
    assign flash_mosi = mosi_q;
    assign a_ready    = a_ready_q;
    assign b_ready    = b_ready_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;

endmodule
